simple_dual_port_ram: RTL and testbench

Single-clock simple dual-port RAM with one dedicated write port and one dedicated read port, usable in the same cycle. It is the storage array under the FIFO and buffering blocks: the controller owns the pointers and the RAM only stores and returns words. Read latency and read-during-write behaviour are set by parameters. A registered valid flag accompanies read data.

---
 rtl/sdp_ram_pkg.sv | 14 +
 rtl/sdp_ram_out_pipe.sv | 47 ++++
 rtl/simple_dual_port_ram.sv | 83 ++++++++
 tb/tb_simple_dual_port_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared constants for the simple dual-port RAM: read-during-write modes,
// default widths and the depth helper.
package sdp_ram_pkg;

  localparam int READ_FIRST     = 0;
  localparam int WRITE_FIRST    = 1;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  function automatic int calc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sdp_ram_out_pipe.sv
// Delay line for read data plus valid; data only advances alongside a valid
// bit so the final stage holds the last completed read.
module sdp_ram_out_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("sdp_ram_out_pipe needs STAGES >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] data_reg [STAGES];
  logic [STAGES-1:0] valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        data_reg[i] <= '0;
      end
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= valid_in;
      if (valid_in) begin
        data_reg[0] <= data_in;
      end
      for (int i = 1; i < STAGES; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        if (valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
    end
  end

  assign data_out  = data_reg[STAGES-1];
  assign valid_out = valid_reg[STAGES-1];

endmodule

// File: rtl/simple_dual_port_ram.sv
// Single-clock simple dual-port RAM: one write port, one read port, registered
// read data with a valid flag and configurable read-during-write behaviour.
module simple_dual_port_ram
  import sdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = READ_FIRST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != READ_FIRST && RDW_MODE != WRITE_FIRST) begin : g_bad_rdw
      $error("RDW_MODE must be READ_FIRST or WRITE_FIRST");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  bypass_hit;
  logic [DATA_WIDTH-1:0] cap_data_reg;
  logic                  cap_valid_reg;

  // Storage has no reset so it can map onto RAM primitives; writes are
  // suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    bypass_hit = (RDW_MODE == WRITE_FIRST) && wr_en && (wr_addr == rd_addr);
    rd_word    = bypass_hit ? wr_data : mem_reg[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data_reg  <= '0;
      cap_valid_reg <= 1'b0;
    end else begin
      cap_valid_reg <= rd_en;
      if (rd_en) begin
        cap_data_reg <= rd_word;
      end
    end
  end

  generate
    if (RD_LATENCY > 1) begin : g_pipe
      sdp_ram_out_pipe #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (RD_LATENCY - 1)
      ) u_out_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (cap_data_reg),
        .valid_in  (cap_valid_reg),
        .data_out  (rd_data),
        .valid_out (rd_valid)
      );
    end else begin : g_direct
      assign rd_data  = cap_data_reg;
      assign rd_valid = cap_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed bench for simple_dual_port_ram: a READ_FIRST/latency-1 instance and a
// WRITE_FIRST/latency-2 instance share one stimulus stream.
module tb_simple_dual_port_ram;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data_rf1;
  logic       rd_valid_rf1;
  logic [7:0] rd_data_wf2;
  logic       rd_valid_wf2;

  int checks = 0;
  int errors = 0;

  simple_dual_port_ram #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .RD_LATENCY (1),
    .RDW_MODE   (0)
  ) u_rf1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_rf1),
    .rd_valid (rd_valid_rf1)
  );

  simple_dual_port_ram #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .RD_LATENCY (2),
    .RDW_MODE   (1)
  ) u_wf2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_wf2),
    .rd_valid (rd_valid_wf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [7:0] d1;
    logic       v1;
    logic [7:0] d2;
    logic       v2;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic re, input logic [3:0] ra,
                              input logic [7:0] d1, input logic v1,
                              input logic [7:0] d2, input logic v2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.d1 = d1; v.v1 = v1; v.d2 = d2; v.v2 = v2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present inputs, let one rising edge sample them, then settle past the edge.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic re, input logic [3:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;

    // Per-edge vectors; d1/v1 for the latency-1 READ_FIRST copy, d2/v2 for
    // the latency-2 WRITE_FIRST copy.
    vecs[0]  = mk(1, 4'd1, 8'hA5, 0, 4'd0, 8'h00, 0, 8'h00, 0);
    vecs[1]  = mk(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 8'h00, 0);
    vecs[2]  = mk(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 8'h00, 0);
    vecs[3]  = mk(0, 4'd0, 8'h00, 1, 4'd1, 8'hA5, 1, 8'h00, 0);
    vecs[4]  = mk(0, 4'd0, 8'h00, 0, 4'd0, 8'hA5, 0, 8'hA5, 1);
    vecs[5]  = mk(0, 4'd0, 8'h00, 0, 4'd0, 8'hA5, 0, 8'hA5, 0);
    vecs[6]  = mk(1, 4'd3, 8'h11, 0, 4'd0, 8'hA5, 0, 8'hA5, 0);
    vecs[7]  = mk(1, 4'd3, 8'h22, 1, 4'd3, 8'h11, 1, 8'hA5, 0);
    vecs[8]  = mk(0, 4'd0, 8'h00, 1, 4'd3, 8'h22, 1, 8'h22, 1);
    vecs[9]  = mk(1, 4'd7, 8'hC3, 0, 4'd0, 8'h22, 0, 8'h22, 1);
    vecs[10] = mk(1, 4'd4, 8'h5A, 1, 4'd7, 8'hC3, 1, 8'h22, 0);
    vecs[11] = mk(0, 4'd0, 8'h00, 1, 4'd4, 8'h5A, 1, 8'hC3, 1);
    vecs[12] = mk(0, 4'd0, 8'h00, 0, 4'd0, 8'h5A, 0, 8'h5A, 1);
    vecs[13] = mk(0, 4'd0, 8'h00, 0, 4'd0, 8'h5A, 0, 8'h5A, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf1_data", rd_data_rf1, 8'h00);
    chk("reset_rf1_valid", {7'd0, rd_valid_rf1}, 8'h00);
    chk("reset_wf2_data", rd_data_wf2, 8'h00);
    chk("reset_wf2_valid", {7'd0, rd_valid_wf2}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      $display("vec %0d we=%b wa=%0d wd=%h re=%b ra=%0d rf1=%h/%b wf2=%h/%b", i,
               vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
               rd_data_rf1, rd_valid_rf1, rd_data_wf2, rd_valid_wf2);
      chk($sformatf("vec%0d_rf1_data", i), rd_data_rf1, vecs[i].d1);
      chk($sformatf("vec%0d_rf1_valid", i), {7'd0, rd_valid_rf1}, {7'd0, vecs[i].v1});
      chk($sformatf("vec%0d_wf2_data", i), rd_data_wf2, vecs[i].d2);
      chk($sformatf("vec%0d_wf2_valid", i), {7'd0, rd_valid_wf2}, {7'd0, vecs[i].v2});
    end

    // Reset asserted between edges while a latency-2 read is in flight.
    drive(0, 4'd0, 8'h00, 1, 4'd1);
    chk("rst_pre_rf1_data", rd_data_rf1, 8'hA5);
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hEE;
    #1;
    $display("async reset asserted rf1=%h/%b wf2=%h/%b", rd_data_rf1, rd_valid_rf1,
             rd_data_wf2, rd_valid_wf2);
    chk("rst_now_rf1_data", rd_data_rf1, 8'h00);
    chk("rst_now_rf1_valid", {7'd0, rd_valid_rf1}, 8'h00);
    chk("rst_now_wf2_data", rd_data_wf2, 8'h00);
    chk("rst_now_wf2_valid", {7'd0, rd_valid_wf2}, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_edge_wf2_valid", {7'd0, rd_valid_wf2}, 8'h00);
    #2;
    wr_en = 1'b0;
    rst_n = 1'b1;
    drive(0, 4'd0, 8'h00, 0, 4'd0);
    chk("post_rst1_rf1_valid", {7'd0, rd_valid_rf1}, 8'h00);
    chk("post_rst1_wf2_valid", {7'd0, rd_valid_wf2}, 8'h00);
    drive(0, 4'd0, 8'h00, 0, 4'd0);
    chk("post_rst2_wf2_valid", {7'd0, rd_valid_wf2}, 8'h00);
    drive(0, 4'd0, 8'h00, 1, 4'd1);
    chk("keep_rf1_data", rd_data_rf1, 8'hA5);
    chk("keep_rf1_valid", {7'd0, rd_valid_rf1}, 8'h01);
    drive(0, 4'd0, 8'h00, 0, 4'd0);
    chk("keep_wf2_data", rd_data_wf2, 8'hA5);
    chk("keep_wf2_valid", {7'd0, rd_valid_wf2}, 8'h01);
    $display("reset sequence rf1=%h/%b wf2=%h/%b", rd_data_rf1, rd_valid_rf1,
             rd_data_wf2, rd_valid_wf2);

    // Sweep: fill every address, then read all back-to-back.
    for (int k = 0; k < 16; k++) begin
      drive(1, 4'(k), 8'(16 + k), 0, 4'd0);
    end
    for (int j = 0; j <= 16; j++) begin
      drive(0, 4'd0, 8'h00, (j < 16), 4'(j));
      $display("sweep %0d rf1=%h/%b wf2=%h/%b", j, rd_data_rf1, rd_valid_rf1,
               rd_data_wf2, rd_valid_wf2);
      if (j < 16) begin
        chk($sformatf("sweep%0d_rf1_data", j), rd_data_rf1, 8'(16 + j));
        chk($sformatf("sweep%0d_rf1_valid", j), {7'd0, rd_valid_rf1}, 8'h01);
      end else begin
        chk("sweep_end_rf1_data", rd_data_rf1, 8'h1F);
        chk("sweep_end_rf1_valid", {7'd0, rd_valid_rf1}, 8'h00);
      end
      if (j == 0) begin
        chk("sweep0_wf2_valid", {7'd0, rd_valid_wf2}, 8'h00);
      end else begin
        chk($sformatf("sweep%0d_wf2_data", j), rd_data_wf2, 8'(15 + j));
        chk($sformatf("sweep%0d_wf2_valid", j), {7'd0, rd_valid_wf2}, 8'h01);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
